// File: rtl/lfsr_prbs_sync_pkg.sv
// Package: lfsr_prbs_sync_pkg
// Purpose : Shared types and helpers for the PRBS checker sequencing controller.
//   state_e     - link state machine encoding (ST_IDLE/ST_RESYNC/ST_HUNT/ST_LOCKED)
//   flush_words - words to discard after a checker resync, ceil(lfsr_w/data_w)
//   cnt_bits    - bits needed to hold the range 0..max_val (at least 1)
package lfsr_prbs_sync_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RESYNC = 2'd1,
      ST_HUNT   = 2'd2,
      ST_LOCKED = 2'd3
   } state_e;

   function automatic int unsigned flush_words(input int unsigned lfsr_w, input int unsigned data_w);
      return (lfsr_w + data_w - 1) / data_w;
   endfunction

   function automatic int unsigned cnt_bits(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/lfsr_prbs_popcount.sv
// Module : lfsr_prbs_popcount
// Purpose: Combinational population count of the checker error vector.
// Ports  :
//   data_i  [DATA_WIDTH]            per-bit error flags
//   count_o [cnt_bits(DATA_WIDTH)]  number of set bits in data_i
module lfsr_prbs_popcount
   import lfsr_prbs_sync_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0]           data_i,
   output logic [cnt_bits(DATA_WIDTH)-1:0] count_o
);

   localparam int unsigned W = cnt_bits(DATA_WIDTH);

   always_comb begin
      count_o = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         count_o = count_o + W'(data_i[i]);
      end
   end

endmodule

// File: rtl/lfsr_prbs_sync_ctrl.sv
// Module : lfsr_prbs_sync_ctrl
// Purpose: Sequencing/monitor controller for a PRBS checker. Drives checker
//          resync, runs the IDLE/RESYNC/HUNT/LOCKED link state machine and keeps
//          saturating bit-error and loss-of-lock statistics.
// Ports  :
//   clk, rst         clock, synchronous active-high reset
//   enable           run monitor; low forces IDLE (statistics retained)
//   clear            zero statistics counters (clear beats increment)
//   err_in           checker error vector, one bit per data bit
//   err_in_valid     err_in qualifier
//   chk_rst          one-cycle resync pulse to the checker
//   locked           link locked
//   lock_lost        one-cycle pulse on loss of lock
//   bit_err_cnt      saturating bit errors counted while locked
//   lock_lost_cnt    saturating loss-of-lock event count
//   word_cnt         (LFSR_PRBS_SYNC_WORD_CNT_EN only) saturating valid words while locked
// Configuration: define LFSR_PRBS_SYNC_WORD_CNT_EN to add the word_cnt output.
module lfsr_prbs_sync_ctrl
   import lfsr_prbs_sync_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned LFSR_WIDTH   = 9,
   parameter int unsigned LOCK_WORDS   = 16,
   parameter int unsigned WINDOW_WORDS = 256,
   parameter int unsigned UNLOCK_ERRS  = 8,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] err_in,
   input  logic                  err_in_valid,
   output logic                  chk_rst,
   output logic                  locked,
   output logic                  lock_lost,
   output logic [CNT_WIDTH-1:0]  bit_err_cnt,
   output logic [CNT_WIDTH-1:0]  lock_lost_cnt
`ifdef LFSR_PRBS_SYNC_WORD_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

   localparam int unsigned FLUSH_WORDS = flush_words(LFSR_WIDTH, DATA_WIDTH);
   localparam int unsigned PC_W = cnt_bits(DATA_WIDTH);
   localparam int unsigned FL_W = cnt_bits(FLUSH_WORDS - 1);
   localparam int unsigned CL_W = cnt_bits(LOCK_WORDS - 1);
   localparam int unsigned WN_W = cnt_bits(WINDOW_WORDS - 1);
   localparam int unsigned EW_W = cnt_bits(UNLOCK_ERRS - 1);
   localparam int unsigned CW1  = CNT_WIDTH + 1;

   localparam logic [FL_W-1:0] FLUSH_LAST  = FL_W'(FLUSH_WORDS - 1);
   localparam logic [CL_W-1:0] LOCK_LAST   = CL_W'(LOCK_WORDS - 1);
   localparam logic [WN_W-1:0] WIN_LAST    = WN_W'(WINDOW_WORDS - 1);
   localparam logic [EW_W-1:0] UNLOCK_LAST = EW_W'(UNLOCK_ERRS - 1);

   state_e               state_q, state_d;
   logic                 chk_rst_q, chk_rst_d;
   logic                 locked_q, locked_d;
   logic                 lock_lost_q, lock_lost_d;
   logic [CNT_WIDTH-1:0] bit_err_q, bit_err_d;
   logic [CNT_WIDTH-1:0] lost_cnt_q, lost_cnt_d;
   logic [FL_W-1:0]      flush_q, flush_d;
   logic [CL_W-1:0]      clean_q, clean_d;
   logic [WN_W-1:0]      win_q, win_d;
   logic [EW_W-1:0]      err_words_q, err_words_d;
`ifdef LFSR_PRBS_SYNC_WORD_CNT_EN
   logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
`endif

   logic [PC_W-1:0]      pc;
   logic [CW1-1:0]       bit_sum;
   logic [CNT_WIDTH-1:0] bit_sat;
   logic                 err_any;

   lfsr_prbs_popcount #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_popcount (
      .data_i  (err_in),
      .count_o (pc)
   );

   // One extra carry bit detects overflow; overflow clamps to all-ones.
   assign bit_sum = CW1'(bit_err_q) + CW1'(pc);
   assign bit_sat = bit_sum[CNT_WIDTH] ? '1 : bit_sum[CNT_WIDTH-1:0];
   assign err_any = |err_in;

   always_comb begin
      state_d     = state_q;
      chk_rst_d   = 1'b0;
      locked_d    = locked_q;
      lock_lost_d = 1'b0;
      bit_err_d   = bit_err_q;
      lost_cnt_d  = lost_cnt_q;
      flush_d     = flush_q;
      clean_d     = clean_q;
      win_d       = win_q;
      err_words_d = err_words_q;
`ifdef LFSR_PRBS_SYNC_WORD_CNT_EN
      word_cnt_d  = word_cnt_q;
`endif

      if (!enable) begin
         state_d     = ST_IDLE;
         locked_d    = 1'b0;
         flush_d     = '0;
         clean_d     = '0;
         win_d       = '0;
         err_words_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d   = ST_RESYNC;
               chk_rst_d = 1'b1;
               flush_d   = '0;
            end
            ST_RESYNC: begin
               // Words seen while the checker reset pulse is asserted are not flush words.
               if (!chk_rst_q && err_in_valid) begin
                  if (flush_q == FLUSH_LAST) begin
                     state_d = ST_HUNT;
                     flush_d = '0;
                     clean_d = '0;
                  end else begin
                     flush_d = flush_q + FL_W'(1);
                  end
               end
            end
            ST_HUNT: begin
               if (err_in_valid) begin
                  if (err_any) begin
                     clean_d = '0;
                  end else if (clean_q == LOCK_LAST) begin
                     state_d     = ST_LOCKED;
                     locked_d    = 1'b1;
                     clean_d     = '0;
                     win_d       = '0;
                     err_words_d = '0;
                  end else begin
                     clean_d = clean_q + CL_W'(1);
                  end
               end
            end
            ST_LOCKED: begin
               if (err_in_valid) begin
                  bit_err_d = bit_sat;
`ifdef LFSR_PRBS_SYNC_WORD_CNT_EN
                  if (word_cnt_q != '1) word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
`endif
                  // Unlock takes priority over the window wrap on the same word.
                  if (err_any && (err_words_q == UNLOCK_LAST)) begin
                     state_d     = ST_RESYNC;
                     chk_rst_d   = 1'b1;
                     locked_d    = 1'b0;
                     lock_lost_d = 1'b1;
                     if (lost_cnt_q != '1) lost_cnt_d = lost_cnt_q + CNT_WIDTH'(1);
                     flush_d     = '0;
                     win_d       = '0;
                     err_words_d = '0;
                  end else if (win_q == WIN_LAST) begin
                     win_d       = '0;
                     err_words_d = '0;
                  end else begin
                     win_d       = win_q + WN_W'(1);
                     err_words_d = err_words_q + EW_W'(err_any);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (clear) begin
         bit_err_d  = '0;
         lost_cnt_d = '0;
`ifdef LFSR_PRBS_SYNC_WORD_CNT_EN
         word_cnt_d = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         chk_rst_q   <= 1'b0;
         locked_q    <= 1'b0;
         lock_lost_q <= 1'b0;
         bit_err_q   <= '0;
         lost_cnt_q  <= '0;
         flush_q     <= '0;
         clean_q     <= '0;
         win_q       <= '0;
         err_words_q <= '0;
`ifdef LFSR_PRBS_SYNC_WORD_CNT_EN
         word_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         chk_rst_q   <= chk_rst_d;
         locked_q    <= locked_d;
         lock_lost_q <= lock_lost_d;
         bit_err_q   <= bit_err_d;
         lost_cnt_q  <= lost_cnt_d;
         flush_q     <= flush_d;
         clean_q     <= clean_d;
         win_q       <= win_d;
         err_words_q <= err_words_d;
`ifdef LFSR_PRBS_SYNC_WORD_CNT_EN
         word_cnt_q  <= word_cnt_d;
`endif
      end
   end

   assign chk_rst       = chk_rst_q;
   assign locked        = locked_q;
   assign lock_lost     = lock_lost_q;
   assign bit_err_cnt   = bit_err_q;
   assign lock_lost_cnt = lost_cnt_q;
`ifdef LFSR_PRBS_SYNC_WORD_CNT_EN
   assign word_cnt      = word_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_prbs_sync_ctrl.sv
// Testbench for lfsr_prbs_sync_ctrl: default instance plus a CNT_WIDTH=4
// instance driven by the same stimulus, checked against a word-level model.
module tb_lfsr_prbs_sync_ctrl;

   localparam int FLUSH  = 2;
   localparam int LOCK_W = 16;
   localparam int WIN_W  = 256;
   localparam int UNL    = 8;

   localparam int P_IDLE = 0, P_PULSE = 1, P_FLUSH = 2, P_HUNT = 3, P_LOCKED = 4;

   logic        clk;
   logic        rst, enable, clear, err_in_valid;
   logic [7:0]  err_in;
   logic        chk_rst, locked, lock_lost;
   logic [31:0] bit_err_cnt, lock_lost_cnt;
   logic        chk_rst4, locked4, lock_lost4;
   logic [3:0]  bit_err_cnt4, lock_lost_cnt4;
`ifdef LFSR_PRBS_SYNC_WORD_CNT_EN
   logic [31:0] word_cnt;
   logic [3:0]  word_cnt4;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int          m_phase, m_flushed, m_clean, m_wpos, m_werrs;
   bit          m_chk, m_locked, m_lost;
   longint unsigned m_bits, m_losses, m_words;

   lfsr_prbs_sync_ctrl u_dut (
      .clk (clk), .rst (rst), .enable (enable), .clear (clear),
      .err_in (err_in), .err_in_valid (err_in_valid),
      .chk_rst (chk_rst), .locked (locked), .lock_lost (lock_lost),
      .bit_err_cnt (bit_err_cnt), .lock_lost_cnt (lock_lost_cnt)
`ifdef LFSR_PRBS_SYNC_WORD_CNT_EN
      , .word_cnt (word_cnt)
`endif
   );

   lfsr_prbs_sync_ctrl #(.CNT_WIDTH (4)) u_dut4 (
      .clk (clk), .rst (rst), .enable (enable), .clear (clear),
      .err_in (err_in), .err_in_valid (err_in_valid),
      .chk_rst (chk_rst4), .locked (locked4), .lock_lost (lock_lost4),
      .bit_err_cnt (bit_err_cnt4), .lock_lost_cnt (lock_lost_cnt4)
`ifdef LFSR_PRBS_SYNC_WORD_CNT_EN
      , .word_cnt (word_cnt4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint unsigned sat(input longint unsigned v, input int unsigned w);
      longint unsigned mx = (64'd1 << w) - 64'd1;
      return (v > mx) ? mx : v;
   endfunction

   // Word-level behaviour: phases and unbounded totals, saturation applied on compare.
   function automatic void model_update();
      m_chk  = 1'b0;
      m_lost = 1'b0;
      if (rst) begin
         m_phase = P_IDLE; m_locked = 1'b0; m_flushed = 0; m_clean = 0;
         m_wpos = 0; m_werrs = 0; m_bits = 0; m_losses = 0; m_words = 0;
      end else begin
         if (!enable) begin
            m_phase  = P_IDLE;
            m_locked = 1'b0;
         end else begin
            case (m_phase)
               P_IDLE:  begin m_phase = P_PULSE; m_chk = 1'b1; end
               P_PULSE: begin m_phase = P_FLUSH; m_flushed = 0; end
               P_FLUSH: if (err_in_valid) begin
                  m_flushed++;
                  if (m_flushed == FLUSH) begin m_phase = P_HUNT; m_clean = 0; end
               end
               P_HUNT: if (err_in_valid) begin
                  m_clean = (err_in == 8'h00) ? m_clean + 1 : 0;
                  if (m_clean == LOCK_W) begin
                     m_phase = P_LOCKED; m_locked = 1'b1; m_wpos = 0; m_werrs = 0;
                  end
               end
               P_LOCKED: if (err_in_valid) begin
                  m_bits += $countones(err_in);
                  m_words++;
                  m_wpos++;
                  if (err_in != 8'h00) m_werrs++;
                  if (m_werrs == UNL) begin
                     m_lost = 1'b1; m_losses++; m_locked = 1'b0; m_chk = 1'b1; m_phase = P_PULSE;
                  end else if (m_wpos == WIN_W) begin
                     m_wpos = 0; m_werrs = 0;
                  end
               end
               default: m_phase = P_IDLE;
            endcase
         end
         if (clear) begin m_bits = 0; m_losses = 0; m_words = 0; end
      end
   endfunction

   task automatic step(input int r, input int e, input int c, input logic [7:0] d, input int v);
      rst = (r != 0); enable = (e != 0); clear = (c != 0); err_in = d; err_in_valid = (v != 0);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic relock();
      step(0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 100 && !m_locked; i++) step(0, 1, 0, 8'h00, 1);
      n_cmp++;
      if (locked !== 1'b1 || !m_locked) begin
         n_bad++; $display("FAIL relock.locked got %0b expected 1", locked);
      end
   endtask

   task automatic test_reset();
      step(1, 0, 0, 8'h00, 0);
      step(1, 1, 1, 8'hFF, 1);
      n_cmp++; if (chk_rst !== 1'b0) begin n_bad++; $display("FAIL reset.chk_rst got %0b expected 0", chk_rst); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset.locked got %0b expected 0", locked); end
      n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL reset.lock_lost got %0b expected 0", lock_lost); end
      n_cmp++; if (bit_err_cnt !== 32'd0) begin n_bad++; $display("FAIL reset.bit_err_cnt got %0d expected 0", bit_err_cnt); end
      n_cmp++; if (lock_lost_cnt !== 32'd0) begin n_bad++; $display("FAIL reset.lock_lost_cnt got %0d expected 0", lock_lost_cnt); end
      n_cmp++; if (bit_err_cnt4 !== 4'd0) begin n_bad++; $display("FAIL reset.bit_err_cnt4 got %0d expected 0", bit_err_cnt4); end
   endtask

   task automatic test_lock_acquire();
      step(0, 1, 0, 8'h00, 1);
      n_cmp++; if (chk_rst !== 1'b1) begin n_bad++; $display("FAIL acq.chk_rst_pulse got %0b expected 1", chk_rst); end
      step(0, 1, 0, 8'h00, 1);
      n_cmp++; if (chk_rst !== 1'b0) begin n_bad++; $display("FAIL acq.chk_rst_end got %0b expected 0", chk_rst); end
      step(0, 1, 0, 8'h00, 1);
      step(0, 1, 0, 8'h00, 1);
      for (int i = 1; i <= LOCK_W; i++) begin
         step(0, 1, 0, 8'h00, 1);
         n_cmp++;
         if (locked !== ((i == LOCK_W) ? 1'b1 : 1'b0)) begin
            n_bad++; $display("FAIL acq.locked clean=%0d got %0b expected %0b", i, locked, (i == LOCK_W));
         end
      end
   endtask

   task automatic test_single_error();
      step(0, 1, 0, 8'h81, 1);
      n_cmp++; if (bit_err_cnt !== 32'd2) begin n_bad++; $display("FAIL single.bit_err_cnt got %0d expected 2", bit_err_cnt); end
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL single.locked got %0b expected 1", locked); end
      n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL single.lock_lost got %0b expected 0", lock_lost); end
      step(0, 1, 0, 8'hFF, 0);
      n_cmp++; if (bit_err_cnt !== 32'd2) begin n_bad++; $display("FAIL single.invalid_hold got %0d expected 2", bit_err_cnt); end
   endtask

   task automatic test_hunt_error();
      step(0, 0, 0, 8'h00, 1);
      step(0, 1, 0, 8'h00, 1);
      step(0, 1, 0, 8'h00, 1);
      step(0, 1, 0, 8'h00, 1);
      step(0, 1, 0, 8'h00, 1);
      for (int i = 0; i < 9; i++) step(0, 1, 0, 8'h00, 1);
      step(0, 1, 0, 8'h01, 1);
      for (int i = 1; i <= LOCK_W; i++) begin
         step(0, 1, 0, 8'h00, 1);
         n_cmp++;
         if (locked !== ((i == LOCK_W) ? 1'b1 : 1'b0)) begin
            n_bad++; $display("FAIL hunt.locked clean=%0d got %0b expected %0b", i, locked, (i == LOCK_W));
         end
      end
   endtask

   task automatic test_unlock();
      relock();
      for (int k = 0; k < UNL; k++) begin
         step(0, 1, 0, 8'h00, 1);
         step(0, 1, 0, 8'($urandom_range(1, 255)), 1);
         n_cmp++;
         if (lock_lost !== ((k == UNL - 1) ? 1'b1 : 1'b0)) begin
            n_bad++; $display("FAIL unlock.lock_lost k=%0d got %0b expected %0b", k, lock_lost, (k == UNL - 1));
         end
      end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL unlock.locked got %0b expected 0", locked); end
      n_cmp++; if (chk_rst !== 1'b1) begin n_bad++; $display("FAIL unlock.chk_rst got %0b expected 1", chk_rst); end
      n_cmp++; if (lock_lost_cnt !== 32'd1) begin n_bad++; $display("FAIL unlock.lock_lost_cnt got %0d expected 1", lock_lost_cnt); end
      n_cmp++; if (bit_err_cnt !== 32'(sat(m_bits, 32))) begin n_bad++; $display("FAIL unlock.bit_err_cnt got %0d expected %0d", bit_err_cnt, m_bits); end
      step(0, 1, 0, 8'h00, 1);
      n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL unlock.pulse_end got %0b expected 0", lock_lost); end
      n_cmp++; if (chk_rst !== 1'b0) begin n_bad++; $display("FAIL unlock.chk_rst_end got %0b expected 0", chk_rst); end
      for (int i = 1; i <= FLUSH + LOCK_W; i++) begin
         step(0, 1, 0, 8'h00, 1);
         n_cmp++;
         if (locked !== ((i == FLUSH + LOCK_W) ? 1'b1 : 1'b0)) begin
            n_bad++; $display("FAIL unlock.relock i=%0d got %0b expected %0b", i, locked, (i == FLUSH + LOCK_W));
         end
      end
   endtask

   task automatic test_window_wrap();
      longint unsigned b0;
      int added;
      int w;
      relock();
      b0 = m_bits;
      added = 0;
      w = 0;
      while (w < 2 * WIN_W) begin
         logic [7:0] d;
         if ($urandom_range(0, 6) == 0) begin
            step(0, 1, 0, 8'hFF, 0);
         end else begin
            d = ((w % WIN_W) % 20 == 5 && (w % WIN_W) < 140) ? 8'($urandom_range(1, 255)) : 8'h00;
            added += $countones(d);
            step(0, 1, 0, d, 1);
            w++;
         end
         n_cmp++;
         if (locked !== 1'b1 || lock_lost !== 1'b0) begin
            n_bad++; $display("FAIL wrap.lock word=%0d got locked=%0b lost=%0b expected 1/0", w, locked, lock_lost);
         end
      end
      n_cmp++;
      if (bit_err_cnt !== 32'(b0 + longint'(added))) begin
         n_bad++; $display("FAIL wrap.bit_err_cnt got %0d expected %0d", bit_err_cnt, b0 + longint'(added));
      end
   endtask

   task automatic test_unlock_window_end();
      relock();
      for (int w = 0; w < WIN_W; w++) begin
         step(0, 1, 0, ((w % 30 == 0 && w < 200) || w == WIN_W - 1) ? 8'h10 : 8'h00, 1);
         n_cmp++;
         if (lock_lost !== ((w == WIN_W - 1) ? 1'b1 : 1'b0)) begin
            n_bad++; $display("FAIL winend.lock_lost word=%0d got %0b expected %0b", w, lock_lost, (w == WIN_W - 1));
         end
      end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL winend.locked got %0b expected 0", locked); end
   endtask

   task automatic test_saturation_clear();
      relock();
      step(0, 1, 1, 8'h00, 0);
      n_cmp++; if (bit_err_cnt4 !== 4'd0) begin n_bad++; $display("FAIL sat.clear0 got %0d expected 0", bit_err_cnt4); end
      step(0, 1, 0, 8'hFF, 1);
      step(0, 1, 0, 8'hFF, 1);
      n_cmp++; if (bit_err_cnt4 !== 4'd15) begin n_bad++; $display("FAIL sat.bit_err_cnt4 got %0d expected 15", bit_err_cnt4); end
      n_cmp++; if (bit_err_cnt !== 32'd16) begin n_bad++; $display("FAIL sat.bit_err_cnt got %0d expected 16", bit_err_cnt); end
      step(0, 1, 1, 8'hFF, 1);
      n_cmp++; if (bit_err_cnt4 !== 4'd0) begin n_bad++; $display("FAIL sat.clear_wins4 got %0d expected 0", bit_err_cnt4); end
      n_cmp++; if (bit_err_cnt !== 32'd0) begin n_bad++; $display("FAIL sat.clear_wins got %0d expected 0", bit_err_cnt); end
      step(0, 1, 0, 8'hFF, 1);
      step(0, 0, 0, 8'hFF, 1);
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL dis.locked got %0b expected 0", locked); end
      n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL dis.lock_lost got %0b expected 0", lock_lost); end
      n_cmp++; if (chk_rst !== 1'b0) begin n_bad++; $display("FAIL dis.chk_rst got %0b expected 0", chk_rst); end
      n_cmp++; if (bit_err_cnt !== 32'd8) begin n_bad++; $display("FAIL dis.retain got %0d expected 8", bit_err_cnt); end
   endtask

   task automatic test_mid_reset();
      relock();
      step(0, 1, 0, 8'h3C, 1);
      step(1, 1, 0, 8'hFF, 1);
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL midrst.locked got %0b expected 0", locked); end
      n_cmp++; if (bit_err_cnt !== 32'd0) begin n_bad++; $display("FAIL midrst.bit_err_cnt got %0d expected 0", bit_err_cnt); end
      n_cmp++; if (lock_lost_cnt !== 32'd0) begin n_bad++; $display("FAIL midrst.lock_lost_cnt got %0d expected 0", lock_lost_cnt); end
   endtask

   task automatic test_random();
      step(1, 0, 0, 8'h00, 0);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         int p;
         logic [7:0] d;
         p = int'($urandom_range(0, 99));
         d = (p < 3) ? 8'($urandom_range(1, 255)) : ((p < 4) ? 8'hFF : 8'h00);
         step(($urandom_range(0, 1499) == 0) ? 1 : 0,
              ($urandom_range(0, 299) != 0) ? 1 : 0,
              ($urandom_range(0, 149) == 0) ? 1 : 0,
              d,
              ($urandom_range(0, 3) != 0) ? 1 : 0);
         n_cmp++; if (chk_rst !== m_chk) begin n_bad++; $display("FAIL rnd.chk_rst cyc=%0d got %0b expected %0b", cyc, chk_rst, m_chk); end
         n_cmp++; if (locked !== m_locked) begin n_bad++; $display("FAIL rnd.locked cyc=%0d got %0b expected %0b", cyc, locked, m_locked); end
         n_cmp++; if (lock_lost !== m_lost) begin n_bad++; $display("FAIL rnd.lock_lost cyc=%0d got %0b expected %0b", cyc, lock_lost, m_lost); end
         n_cmp++; if (bit_err_cnt !== 32'(sat(m_bits, 32))) begin n_bad++; $display("FAIL rnd.bit_err_cnt cyc=%0d got %0d expected %0d", cyc, bit_err_cnt, m_bits); end
         n_cmp++; if (lock_lost_cnt !== 32'(sat(m_losses, 32))) begin n_bad++; $display("FAIL rnd.lock_lost_cnt cyc=%0d got %0d expected %0d", cyc, lock_lost_cnt, m_losses); end
         n_cmp++; if (bit_err_cnt4 !== 4'(sat(m_bits, 4))) begin n_bad++; $display("FAIL rnd.bit_err_cnt4 cyc=%0d got %0d expected %0d", cyc, bit_err_cnt4, sat(m_bits, 4)); end
         n_cmp++; if (lock_lost_cnt4 !== 4'(sat(m_losses, 4))) begin n_bad++; $display("FAIL rnd.lock_lost_cnt4 cyc=%0d got %0d expected %0d", cyc, lock_lost_cnt4, sat(m_losses, 4)); end
         n_cmp++; if (locked4 !== m_locked || chk_rst4 !== m_chk || lock_lost4 !== m_lost) begin
            n_bad++; $display("FAIL rnd.flags4 cyc=%0d got %0b%0b%0b expected %0b%0b%0b", cyc, locked4, chk_rst4, lock_lost4, m_locked, m_chk, m_lost);
         end
`ifdef LFSR_PRBS_SYNC_WORD_CNT_EN
         n_cmp++; if (word_cnt !== 32'(sat(m_words, 32))) begin n_bad++; $display("FAIL rnd.word_cnt cyc=%0d got %0d expected %0d", cyc, word_cnt, m_words); end
         n_cmp++; if (word_cnt4 !== 4'(sat(m_words, 4))) begin n_bad++; $display("FAIL rnd.word_cnt4 cyc=%0d got %0d expected %0d", cyc, word_cnt4, sat(m_words, 4)); end
`endif
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; clear = 1'b0; err_in = 8'h00; err_in_valid = 1'b0;
      test_reset();
      test_lock_acquire();
      test_single_error();
      test_hunt_error();
      test_unlock();
      test_window_wrap();
      test_unlock_window_end();
      test_saturation_clear();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
